// File: rtl/hash_result_checker.sv
// hash_result_checker: scans NUM_NONCES hash words and reports the minimum hash and the hits below target.
// Optional feature macro HASH_CHECK_WRITEBACK_EN adds a two-word summary write to result_addr.
module hash_result_checker #(
  parameter int NUM_NONCES = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [15:0] hash_addr,
  input  logic [15:0] result_addr,
  input  logic [31:0] target,
  output logic        done,
  output logic        found,
  output logic [7:0]  best_nonce,
  output logic [31:0] min_hash,
  output logic [8:0]  hit_count,
  output logic        mem_clk,
  output logic        mem_we,
  output logic [15:0] mem_addr,
  output logic [31:0] mem_write_data,
  input  logic [31:0] mem_read_data
);

`ifdef HASH_CHECK_WRITEBACK_EN
  typedef enum logic [1:0] {IDLE = 2'd0, READ = 2'd1, WRITE = 2'd2, DONE = 2'd3} state_t;
`else
  typedef enum logic [1:0] {IDLE = 2'd0, READ = 2'd1, DONE = 2'd3} state_t;
`endif

  // cnt_q counts READ cycles: address cnt_q is on the bus, word cnt_q-1 is on the data return.
  localparam logic [8:0] LAST_CNT  = 9'(NUM_NONCES);
  localparam logic [8:0] LAST_ADDR = 9'(NUM_NONCES - 1);

  state_t      state_q, state_d;
  logic [8:0]  cnt_q, cnt_d;
  logic [15:0] hash_base_q, hash_base_d;
  logic [31:0] target_q, target_d;
  logic [31:0] min_hash_q, min_hash_d;
  logic [7:0]  best_q, best_d;
  logic [8:0]  hit_q, hit_d;
  logic        done_q, done_d;
  logic [15:0] mem_addr_q, mem_addr_d;

`ifdef HASH_CHECK_WRITEBACK_EN
  logic [15:0] result_base_q, result_base_d;
  logic        wr_phase_q, wr_phase_d;
  logic        mem_we_q, mem_we_d;
  logic [31:0] mem_wdata_q, mem_wdata_d;
`else
  logic        unused_result_addr;
  assign unused_result_addr = ^result_addr;
`endif

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    hash_base_d = hash_base_q;
    target_d    = target_q;
    min_hash_d  = min_hash_q;
    best_d      = best_q;
    hit_d       = hit_q;
    done_d      = 1'b0;
    mem_addr_d  = mem_addr_q;
`ifdef HASH_CHECK_WRITEBACK_EN
    result_base_d = result_base_q;
    wr_phase_d    = wr_phase_q;
    mem_we_d      = 1'b0;
    mem_wdata_d   = mem_wdata_q;
`endif

    case (state_q)
      IDLE: begin
        if (start) begin
          hash_base_d = hash_addr;
          target_d    = target;
          mem_addr_d  = hash_addr;
          cnt_d       = 9'd0;
          min_hash_d  = 32'hFFFF_FFFF;
          best_d      = 8'd0;
          hit_d       = 9'd0;
`ifdef HASH_CHECK_WRITEBACK_EN
          result_base_d = result_addr;
`endif
          state_d     = READ;
        end
      end

      READ: begin
        cnt_d = cnt_q + 9'd1;
        if (cnt_q < LAST_ADDR) begin
          mem_addr_d = hash_base_q + 16'(cnt_q) + 16'd1;
        end
        if (cnt_q != 9'd0) begin
          // Strict compare keeps the lower index on ties.
          if (cnt_q == 9'd1 || mem_read_data < min_hash_q) begin
            min_hash_d = mem_read_data;
            best_d     = 8'(cnt_q - 9'd1);
          end
          if (mem_read_data < target_q) begin
            hit_d = hit_q + 9'd1;
          end
        end
        if (cnt_q == LAST_CNT) begin
`ifdef HASH_CHECK_WRITEBACK_EN
          state_d     = WRITE;
          wr_phase_d  = 1'b0;
          mem_we_d    = 1'b1;
          mem_addr_d  = result_base_q;
          mem_wdata_d = min_hash_d;
`else
          state_d     = DONE;
`endif
        end
      end

`ifdef HASH_CHECK_WRITEBACK_EN
      WRITE: begin
        if (!wr_phase_q) begin
          wr_phase_d  = 1'b1;
          mem_we_d    = 1'b1;
          mem_addr_d  = result_base_q + 16'd1;
          mem_wdata_d = {(hit_q != 9'd0), hit_q, 14'b0, best_q};
        end else begin
          state_d = DONE;
        end
      end
`endif

      DONE: begin
        done_d  = 1'b1;
        state_d = IDLE;
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      cnt_q       <= 9'd0;
      hash_base_q <= 16'd0;
      target_q    <= 32'd0;
      min_hash_q  <= 32'hFFFF_FFFF;
      best_q      <= 8'd0;
      hit_q       <= 9'd0;
      done_q      <= 1'b0;
      mem_addr_q  <= 16'd0;
`ifdef HASH_CHECK_WRITEBACK_EN
      result_base_q <= 16'd0;
      wr_phase_q    <= 1'b0;
      mem_we_q      <= 1'b0;
      mem_wdata_q   <= 32'd0;
`endif
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      hash_base_q <= hash_base_d;
      target_q    <= target_d;
      min_hash_q  <= min_hash_d;
      best_q      <= best_d;
      hit_q       <= hit_d;
      done_q      <= done_d;
      mem_addr_q  <= mem_addr_d;
`ifdef HASH_CHECK_WRITEBACK_EN
      result_base_q <= result_base_d;
      wr_phase_q    <= wr_phase_d;
      mem_we_q      <= mem_we_d;
      mem_wdata_q   <= mem_wdata_d;
`endif
    end
  end

  assign mem_clk    = clk;
  assign mem_addr   = mem_addr_q;
  assign done       = done_q;
  assign found      = (hit_q != 9'd0);
  assign best_nonce = best_q;
  assign min_hash   = min_hash_q;
  assign hit_count  = hit_q;
`ifdef HASH_CHECK_WRITEBACK_EN
  assign mem_we         = mem_we_q;
  assign mem_write_data = mem_wdata_q;
`else
  assign mem_we         = 1'b0;
  assign mem_write_data = 32'd0;
`endif

endmodule

// File: tb/tb_hash_result_checker.sv
// Bench for hash_result_checker: directed vector table, mid-scan reset, and random scans vs a reference model.
module tb_hash_result_checker;
  localparam int NUM = 16;
`ifdef HASH_CHECK_WRITEBACK_EN
  localparam int EXP_LAT = NUM + 4;
`else
  localparam int EXP_LAT = NUM + 2;
`endif

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [15:0] hash_addr = 16'd0;
  logic [15:0] result_addr = 16'd0;
  logic [31:0] target = 32'd0;
  logic        done, found, mem_clk, mem_we;
  logic [7:0]  best_nonce;
  logic [31:0] min_hash, mem_write_data;
  logic [8:0]  hit_count;
  logic [15:0] mem_addr;
  logic [31:0] mem_read_data = 32'd0;

  int checks = 0;
  int failures = 0;

  logic [31:0] mem [65536];
  logic [31:0] hw [NUM];
  logic [15:0] wlog_addr [$];
  logic [31:0] wlog_data [$];

  hash_result_checker #(.NUM_NONCES(NUM)) dut (
    .clk(clk), .reset(reset), .start(start), .hash_addr(hash_addr),
    .result_addr(result_addr), .target(target), .done(done), .found(found),
    .best_nonce(best_nonce), .min_hash(min_hash), .hit_count(hit_count),
    .mem_clk(mem_clk), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_write_data(mem_write_data), .mem_read_data(mem_read_data)
  );

  always #5 clk = ~clk;

  // Synchronous one-cycle-latency memory; writes are only logged.
  always @(posedge mem_clk) begin
    mem_read_data <= mem[mem_addr];
    if (mem_we) begin
      wlog_addr.push_back(mem_addr);
      wlog_data.push_back(mem_write_data);
    end
  end

  typedef struct {
    int          pat;
    logic [15:0] base;
    logic [31:0] tgt;
    int          glitch;
    logic [31:0] e_min;
    logic [7:0]  e_best;
    logic [8:0]  e_hits;
  } vec_t;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  function automatic logic [31:0] pat_word(input int pat, input int i);
    case (pat)
      0, 4:    return 32'(i) * 32'h1000_0000 + 32'd5;
      1:       return 32'h1234_5678;
      2:       return (i == 9) ? 32'd1 : 32'hFFFF_FFF0;
      3:       return 32'h1000 - 32'(i) * 32'h10;
      5:       return (i % 2 == 1) ? 32'hFFFF_FFFF : 32'(i) * 32'd3 + 32'd7;
      6:       return (i == 4 || i == 11) ? 32'h100 : 32'h8000_0000;
      default: return 32'd0;
    endcase
  endfunction

  task automatic load(input logic [15:0] base);
    for (int i = 0; i < NUM; i++) mem[base + 16'(i)] = hw[i];
    mem[base - 16'd1]      = 32'd0;
    mem[base + 16'(NUM)]   = 32'd0;
  endtask

  task automatic model(input logic [31:0] tgt, output logic [31:0] m,
                       output logic [7:0] b, output logic [8:0] h);
    m = 32'hFFFF_FFFF; b = 8'd0; h = 9'd0;
    for (int i = 0; i < NUM; i++) begin
      if (i == 0 || hw[i] < m) begin m = hw[i]; b = 8'(i); end
      if (hw[i] < tgt) h = h + 9'd1;
    end
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_rst_done"}, {31'd0, done}, 32'd0);
    chk({tag, "_rst_found"}, {31'd0, found}, 32'd0);
    chk({tag, "_rst_best"}, {24'd0, best_nonce}, 32'd0);
    chk({tag, "_rst_min"}, min_hash, 32'hFFFF_FFFF);
    chk({tag, "_rst_hits"}, {23'd0, hit_count}, 32'd0);
    chk({tag, "_rst_we"}, {31'd0, mem_we}, 32'd0);
    chk({tag, "_rst_addr"}, {16'd0, mem_addr}, 32'd0);
    chk({tag, "_rst_wdata"}, mem_write_data, 32'd0);
  endtask

  task automatic run_scan(input string nm, input logic [15:0] base, input logic [15:0] res,
                          input logic [31:0] tgt, input int glitch, input logic [31:0] e_min,
                          input logic [7:0] e_best, input logic [8:0] e_hits);
    int done_cyc, done_cnt, addr_bad, wr0;
    logic e_found;
    e_found  = (e_hits != 9'd0);
    wr0      = wlog_addr.size();
    done_cyc = -1; done_cnt = 0; addr_bad = 0;
    @(negedge clk);
    start = 1'b1; hash_addr = base; result_addr = res; target = tgt;
    @(posedge clk); #1;
    start = 1'b0; hash_addr = ~base; result_addr = ~res; target = ~tgt;
    if (mem_addr !== base) addr_bad++;
    for (int c = 1; c <= EXP_LAT + 4; c++) begin
      if (c == glitch) start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      if (c < NUM && mem_addr !== base + 16'(c)) addr_bad++;
      if (done === 1'b1) begin
        done_cnt++;
        if (done_cyc < 0) done_cyc = c;
      end
    end
    chk({nm, "_addrseq"}, 32'(addr_bad), 32'd0);
    chk({nm, "_done_cycle"}, 32'(done_cyc), 32'(EXP_LAT));
    chk({nm, "_done_width"}, 32'(done_cnt), 32'd1);
    chk({nm, "_min"}, min_hash, e_min);
    chk({nm, "_best"}, {24'd0, best_nonce}, {24'd0, e_best});
    chk({nm, "_hits"}, {23'd0, hit_count}, {23'd0, e_hits});
    chk({nm, "_found"}, {31'd0, found}, {31'd0, e_found});
`ifdef HASH_CHECK_WRITEBACK_EN
    chk({nm, "_nwrites"}, 32'(wlog_addr.size() - wr0), 32'd2);
    if (wlog_addr.size() - wr0 == 2) begin
      chk({nm, "_wr0_addr"}, {16'd0, wlog_addr[wr0]}, {16'd0, res});
      chk({nm, "_wr0_data"}, wlog_data[wr0], e_min);
      chk({nm, "_wr1_addr"}, {16'd0, wlog_addr[wr0 + 1]}, {16'd0, res + 16'd1});
      chk({nm, "_wr1_data"}, wlog_data[wr0 + 1], {e_found, e_hits, 14'b0, e_best});
    end
`else
    chk({nm, "_nwrites"}, 32'(wlog_addr.size() - wr0), 32'd0);
`endif
    $display("scan %s base=%h tgt=%h min=%h best=%0d hits=%0d done_cycle=%0d",
             nm, base, tgt, min_hash, best_nonce, hit_count, done_cyc);
  endtask

  initial begin
    vec_t tbl [7];
    logic [31:0] m;
    logic [7:0]  b;
    logic [8:0]  h;
    logic [15:0] rb;
    logic [31:0] rt;
    int          wr0, stray_done;

    tbl[0] = '{0, 16'h0000, 32'h3000_0000, 0, 32'd5,         8'd0,  9'd3};
    tbl[1] = '{1, 16'h1234, 32'h1234_5678, 0, 32'h1234_5678, 8'd0,  9'd0};
    tbl[2] = '{2, 16'h8000, 32'h0000_0002, 5, 32'd1,         8'd9,  9'd1};
    tbl[3] = '{3, 16'hFFF8, 32'h0000_0F80, 0, 32'h0000_0F10, 8'd15, 9'd7};
    tbl[4] = '{4, 16'h0300, 32'h0000_0000, 0, 32'd5,         8'd0,  9'd0};
    tbl[5] = '{5, 16'h4000, 32'hFFFF_FFFF, 0, 32'd7,         8'd0,  9'd8};
    tbl[6] = '{6, 16'h7FF0, 32'h0000_0100, 3, 32'h100,       8'd4,  9'd0};

    repeat (3) @(posedge clk);
    #1;
    chk_reset("init");
    @(negedge clk);
    reset = 1'b0;

    for (int v = 0; v < 7; v++) begin
      for (int i = 0; i < NUM; i++) hw[i] = pat_word(tbl[v].pat, i);
      load(tbl[v].base);
      run_scan($sformatf("vec%0d", v), tbl[v].base, 16'h0040, tbl[v].tgt, tbl[v].glitch,
               tbl[v].e_min, tbl[v].e_best, tbl[v].e_hits);
    end

    // Reset in the middle of a scan.
    for (int i = 0; i < NUM; i++) hw[i] = pat_word(0, i);
    load(16'h0100);
    wr0 = wlog_addr.size();
    @(negedge clk);
    start = 1'b1; hash_addr = 16'h0100; result_addr = 16'h0040; target = 32'h3000_0000;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (6) begin @(posedge clk); #1; end
    reset = 1'b1;
    @(posedge clk); #1;
    chk_reset("midscan");
    reset = 1'b0;
    stray_done = 0;
    repeat (EXP_LAT + 4) begin
      @(posedge clk); #1;
      if (done === 1'b1) stray_done++;
    end
    chk("midscan_stray_done", 32'(stray_done), 32'd0);
    chk("midscan_nwrites", 32'(wlog_addr.size() - wr0), 32'd0);
    $display("midscan reset applied, stray_done=%0d writes=%0d", stray_done, wlog_addr.size() - wr0);
    run_scan("after_reset", 16'h0100, 16'h0040, 32'h3000_0000, 0, 32'd5, 8'd0, 9'd3);

    for (int r = 0; r < 6; r++) begin
      rb = 16'($urandom_range(0, 65535));
      rt = ($urandom_range(0, 1) == 0) ? 32'($urandom_range(0, 20)) : $urandom();
      for (int i = 0; i < NUM; i++)
        hw[i] = ($urandom_range(0, 2) == 0) ? 32'($urandom_range(0, 15)) : $urandom();
      load(rb);
      model(rt, m, b, h);
      run_scan($sformatf("rand%0d", r), rb, 16'($urandom_range(0, 65535)), rt, 0, m, b, h);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
